trigger_window_packer: RTL and testbench

- Consumes the time-multiplexed output of the threshold comparator: per-chip `triggered` flags and the pretrigger-delayed samples, one channel slot per clock.
- On a trigger it captures a fixed-length window of samples for that (chip, channel) across successive frames.
- Each captured sample is emitted as a self-describing 32-bit word on a per-chip lane, into downstream per-lane FIFOs.

---
 rtl/trigger_window_packer.sv | 173 +++++++++++++++++
 tb/tb_trigger_window_packer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_window_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : trigger_window_packer
// Description : Watches the time-multiplexed comparator stream, one channel
//               slot per clock. A trigger on (chip, channel) opens a window of
//               WINDOW samples for that slot over successive frames. Each
//               sample is emitted on the chip's lane as a 32-bit word:
//                 [31] first, [30] last, [29:16] frame, [15:11] channel,
//                 [10] 0, [9:0] sample (zero-extended).
//               If the lane FIFO is full when a word is due, the word is
//               dropped, the window is aborted and drop_count is incremented.
// Ports       : clk, rst             clock, synchronous active-high reset
//               enable               stream active; low clears counters/windows
//               triggered[N]         per-chip trigger for the current slot
//               delayed_signals      per-chip sample, chip c at [c*N_BITS +: N_BITS]
//               lane_full[N]         per-lane downstream full flag
//               word_valid[N]        per-lane single-cycle word strobe
//               word_data[N*32]      per-lane word, lane c at [c*32 +: 32]
//               drop_count[16]       saturating count of dropped words
// Options     : RETRIGGER_EXTEND_EN  when defined, a trigger during an open
//                                    window reloads it (window extension).
// Revision    : 1.0 - initial release
// ============================================================================
module trigger_window_packer #(
    parameter int N        = 4,
    parameter int N_BITS   = 10,
    parameter int CHANNELS = 32,
    parameter int WINDOW   = 4,
    parameter int TS_BITS  = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [N-1:0]        triggered,
    input  logic [N*N_BITS-1:0] delayed_signals,
    input  logic [N-1:0]        lane_full,
    output logic [N-1:0]        word_valid,
    output logic [N*32-1:0]     word_data,
    output logic [15:0]         drop_count
);

    localparam int c_REM_W = $clog2(WINDOW + 1);
    localparam int c_CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int c_DC_W  = $clog2(N + 1);
    localparam logic [c_REM_W-1:0] c_RELOAD = c_REM_W'(WINDOW - 1);
    localparam logic [c_REM_W-1:0] c_ONE    = c_REM_W'(1);

    // ------------------------------------------------------------------
    // Slot / frame counters
    // ------------------------------------------------------------------
    logic [c_CH_W-1:0]  r_slot;
    logic [TS_BITS-1:0] r_frame;
    logic [4:0]         w_ch;

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_slot  <= '0;
            r_frame <= '0;
        end else if (r_slot == c_CH_W'(CHANNELS - 1)) begin
            r_slot  <= '0;
            r_frame <= r_frame + TS_BITS'(1);
        end else begin
            r_slot  <= r_slot + c_CH_W'(1);
        end
    end

    assign w_ch = 5'(r_slot);

    // ------------------------------------------------------------------
    // Per-lane window state and word register
    // ------------------------------------------------------------------
    logic [N-1:0] w_drop;

    for (genvar c = 0; c < N; c++) begin : g_lane
        logic [c_REM_W-1:0] r_rem [CHANNELS];
        logic [c_REM_W-1:0] w_rem;
        logic [c_REM_W-1:0] w_rem_next;
        logic               w_emit;
        logic               w_first;
        logic               w_last;
        logic [9:0]         w_sample;
        logic               r_valid;
        logic [31:0]        r_data;

        assign w_rem    = r_rem[r_slot];
        assign w_sample = 10'(delayed_signals[c*N_BITS +: N_BITS]);

        always_comb begin
            w_emit     = 1'b0;
            w_first    = 1'b0;
            w_last     = 1'b0;
            w_rem_next = w_rem;
            if (w_rem == '0) begin
                if (triggered[c]) begin
                    w_emit     = 1'b1;
                    w_first    = 1'b1;
                    w_last     = (WINDOW == 1);
                    w_rem_next = c_RELOAD;
                end
            end else begin
                w_emit = 1'b1;
`ifdef RETRIGGER_EXTEND_EN
                // A retrigger restarts the countdown; the word is a
                // continuation, so neither first nor last is set.
                if (triggered[c]) begin
                    w_rem_next = c_RELOAD;
                end else begin
                    w_last     = (w_rem == c_ONE);
                    w_rem_next = w_rem - c_ONE;
                end
`else
                w_last     = (w_rem == c_ONE);
                w_rem_next = w_rem - c_ONE;
`endif
            end
        end

        assign w_drop[c] = enable & w_emit & lane_full[c];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < CHANNELS; i++) r_rem[i] <= '0;
                r_valid <= 1'b0;
                r_data  <= '0;
            end else if (!enable) begin
                // Open windows are abandoned without a last word.
                for (int i = 0; i < CHANNELS; i++) r_rem[i] <= '0;
                r_valid <= 1'b0;
            end else begin
                // A dropped word aborts the window so a partial window is
                // never delivered downstream.
                r_rem[r_slot] <= lane_full[c] ? '0 : w_rem_next;
                r_valid       <= w_emit & ~lane_full[c];
                if (w_emit && !lane_full[c]) begin
                    r_data <= {w_first, w_last, r_frame, w_ch, 1'b0, w_sample};
                end
            end
        end

        assign word_valid[c]         = r_valid;
        assign word_data[c*32 +: 32] = r_data;
    end

    // ------------------------------------------------------------------
    // Saturating drop counter
    // ------------------------------------------------------------------
    logic [c_DC_W-1:0] w_ndrop;
    logic [16:0]       w_drop_sum;
    logic [15:0]       r_drop_count;

    always_comb begin
        w_ndrop = '0;
        for (int i = 0; i < N; i++) begin
            w_ndrop = w_ndrop + c_DC_W'(w_drop[i]);
        end
        w_drop_sum = {1'b0, r_drop_count} + 17'(w_ndrop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count <= '0;
        end else if (w_drop_sum[16]) begin
            r_drop_count <= 16'hFFFF;
        end else begin
            r_drop_count <= w_drop_sum[15:0];
        end
    end

    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_trigger_window_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_trigger_window_packer
// Description : Scoreboard bench. The stimulus process pushes expected words
//               per lane with their due cycle; a monitor on the falling edge
//               pops and compares whenever a lane presents a word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trigger_window_packer;

    localparam int NL = 4;
    localparam logic [NL*10-1:0] FILL = {10'h2A5, 10'h15A, 10'h0F0, 10'h30C};
`ifdef RETRIGGER_EXTEND_EN
    localparam int RT_WORDS = 6;
`else
    localparam int RT_WORDS = 4;
`endif

    logic              clk;
    logic              rst;
    logic              enable;
    logic [NL-1:0]     triggered;
    logic [NL*10-1:0]  delayed_signals;
    logic [NL-1:0]     lane_full;
    logic [NL-1:0]     word_valid;
    logic [NL*32-1:0]  word_data;
    logic [15:0]       drop_count;

    trigger_window_packer #(
        .N(NL), .N_BITS(10), .CHANNELS(32), .WINDOW(4), .TS_BITS(14)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .triggered(triggered),
        .delayed_signals(delayed_signals), .lane_full(lane_full),
        .word_valid(word_valid), .word_data(word_data), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] due;
        logic [31:0] w;
    } exp_t;

    exp_t exp_q [NL][$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   tb_slot = 0;
    int   tb_frame = 0;
    int   drop_chk_cyc = -1;
    int   drop_exp = 0;
    int   final_drops = 1;
    logic done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mk(input logic f, input logic l, input int fr,
                                        input int ch, input logic [9:0] s);
        logic [31:0] fr_v;
        logic [31:0] ch_v;
        fr_v = fr;
        ch_v = ch;
        return {f, l, fr_v[13:0], ch_v[4:0], 1'b0, s};
    endfunction

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (cyc >= 1 && cyc <= 3) begin
            total++;
            if (word_valid !== '0 || word_data !== '0 || drop_count !== 16'd0) begin
                bad++;
                $display("FAIL reset_state cyc=%0d got valid=%b data=%h drops=%0d required all zero",
                         cyc, word_valid, word_data, drop_count);
            end
        end else if (cyc > 3) begin
            for (int c = 0; c < NL; c++) begin
                if (word_valid[c]) begin
                    exp_t e;
                    total++;
                    if (exp_q[c].size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_word lane%0d cyc=%0d got=%h required no word",
                                 c, cyc, word_data[c*32 +: 32]);
                    end else begin
                        e = exp_q[c].pop_front();
                        if (e.w !== word_data[c*32 +: 32] || e.due != 32'(cyc)) begin
                            bad++;
                            $display("FAIL word lane%0d got=%h at cyc %0d required=%h at cyc %0d",
                                     c, word_data[c*32 +: 32], cyc, e.w, e.due);
                        end
                    end
                end
            end
            if (cyc == drop_chk_cyc) begin
                total++;
                if (drop_count !== 16'(drop_exp)) begin
                    bad++;
                    $display("FAIL drop_count got=%0d required=%0d", drop_count, drop_exp);
                end
            end
        end
        if (done) begin
            for (int c = 0; c < NL; c++) begin
                total++;
                if (exp_q[c].size() != 0) begin
                    bad++;
                    $display("FAIL missing_words lane%0d got %0d words outstanding required 0",
                             c, exp_q[c].size());
                end
            end
            total++;
            if (drop_count !== 16'(final_drops)) begin
                bad++;
                $display("FAIL final_drop_count got=%0d required=%0d", drop_count, final_drops);
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step(input logic [NL-1:0] t, input logic [NL*10-1:0] d,
                        input logic [NL-1:0] fl, input logic en);
        triggered       = t;
        delayed_signals = d;
        lane_full       = fl;
        enable          = en;
        @(posedge clk);
        #1;
        if (en) begin
            tb_slot++;
            if (tb_slot == 32) begin
                tb_slot = 0;
                tb_frame++;
            end
        end else begin
            tb_slot  = 0;
            tb_frame = 0;
        end
    endtask

    task automatic restart();
        step('0, FILL, '0, 1'b0);
    endtask

    task automatic run_to(input int f, input int ch);
        int guard;
        guard = 0;
        while (!(tb_frame == f && tb_slot == ch)) begin
            step('0, FILL, '0, 1'b1);
            guard++;
            if (guard > 2000) begin
                $display("FAIL run_to frame %0d slot %0d not reached", f, ch);
                $fatal(1, "stimulus position unreachable");
            end
        end
    endtask

    task automatic single(input int c, input logic trig, input logic [9:0] s,
                          input logic full, input logic push, input logic [31:0] w);
        logic [NL-1:0]    t;
        logic [NL*10-1:0] d;
        logic [NL-1:0]    fl;
        exp_t             e;
        t  = '0;
        d  = FILL;
        fl = '0;
        t[c]          = trig;
        d[c*10 +: 10] = s;
        fl[c]         = full;
        if (push) begin
            e.due = 32'(cyc + 1);
            e.w   = w;
            exp_q[c].push_back(e);
        end
        step(t, d, fl, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        rst             = 1'b1;
        enable          = 1'b1;
        triggered       = '1;
        delayed_signals = {NL{10'h3FF}};
        lane_full       = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // First enabled cycle after reset is slot 0, frame 0.
        single(0, 1'b1, 10'h001, 1'b0, 1'b1, 32'h8000_0001);
        for (int f = 1; f <= 3; f++) begin
            run_to(f, 0);
            single(0, 1'b0, 10'(1 + f), 1'b0, 1'b1, mk(1'b0, f == 3, f, 0, 10'(1 + f)));
        end

        // Basic window on chip 0, channel 3.
        restart();
        run_to(0, 3);
        single(0, 1'b1, 10'h123, 1'b0, 1'b1, 32'h8000_1923);
        run_to(1, 3);
        single(0, 1'b0, 10'h124, 1'b0, 1'b1, 32'h0001_1924);
        run_to(2, 3);
        single(0, 1'b0, 10'h125, 1'b0, 1'b1, 32'h0002_1925);
        run_to(3, 3);
        single(0, 1'b0, 10'h126, 1'b0, 1'b1, 32'h4003_1926);

        // Simultaneous windows on lanes 1 and 2, channel 5.
        restart();
        for (int f = 0; f <= 3; f++) begin
            logic [NL*10-1:0] d;
            logic [9:0]       s1;
            logic [9:0]       s2;
            exp_t             e;
            run_to(f, 5);
            s1 = 10'(10'h055 + f);
            s2 = 10'(10'h3AA - f);
            d = FILL;
            d[10 +: 10] = s1;
            d[20 +: 10] = s2;
            e.due = 32'(cyc + 1);
            e.w   = mk(f == 0, f == 3, f, 5, s1);
            exp_q[1].push_back(e);
            e.w   = mk(f == 0, f == 3, f, 5, s2);
            exp_q[2].push_back(e);
            step((f == 0) ? 4'b0110 : 4'b0000, d, '0, 1'b1);
        end

        // Drop on the second word aborts the window; a later trigger restarts.
        restart();
        run_to(0, 3);
        single(0, 1'b1, 10'h010, 1'b0, 1'b1, mk(1'b1, 1'b0, 0, 3, 10'h010));
        run_to(1, 3);
        drop_chk_cyc = cyc + 1;
        drop_exp     = 1;
        // Lane 1 is also full but idle: it must not count as a drop.
        step('0, FILL, 4'b0011, 1'b1);
        run_to(5, 3);
        single(0, 1'b1, 10'h020, 1'b0, 1'b1, mk(1'b1, 1'b0, 5, 3, 10'h020));
        for (int f = 6; f <= 8; f++) begin
            run_to(f, 3);
            single(0, 1'b0, 10'(10'h020 + f), 1'b0, 1'b1,
                   mk(1'b0, f == 8, f, 3, 10'(10'h020 + f)));
        end

        // Enable dropped mid-window: window aborted, counters restart.
        restart();
        run_to(0, 7);
        single(3, 1'b1, 10'h3FF, 1'b0, 1'b1, mk(1'b1, 1'b0, 0, 7, 10'h3FF));
        run_to(1, 7);
        single(3, 1'b0, 10'h3FE, 1'b0, 1'b1, mk(1'b0, 1'b0, 1, 7, 10'h3FE));
        run_to(1, 10);
        repeat (3) restart();
        run_to(2, 0);
        single(3, 1'b1, 10'h155, 1'b0, 1'b1, mk(1'b1, 1'b0, 2, 0, 10'h155));
        for (int f = 3; f <= 5; f++) begin
            run_to(f, 0);
            single(3, 1'b0, 10'(10'h150 + f), 1'b0, 1'b1,
                   mk(1'b0, f == 5, f, 0, 10'(10'h150 + f)));
        end

        // Retrigger inside an open window.
        restart();
        for (int f = 0; f <= 6; f++) begin
            run_to(f, 3);
            single(0, (f == 0) || (f == 2), 10'(10'h200 + f), 1'b0, f < RT_WORDS,
                   mk(f == 0, f == RT_WORDS - 1, f, 3, 10'(10'h200 + f)));
        end

        repeat (4) step('0, FILL, '0, 1'b1);
        done = 1'b1;
    end

endmodule
`default_nettype wire
